key_debounce_encoder: RTL and testbench

- Front-end stage for the two-key combination lock. Sits between the raw push-buttons key0/key1 and the sequence-check/unlock logic.
- Synchronises and debounces both keys, then emits exactly one clean single-cycle press pulse per physical press.
- Encodes each accepted press as a serial code bit (key0 -> 0, key1 -> 1) with a valid strobe. The downstream lock consumes this as its only input.

---
 rtl/key_debounce_encoder.sv | 160 ++++++++++++++++
 tb/tb_key_debounce_encoder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce_encoder.sv
// Two-key front end: 2-FF sync, per-key debounce FSM, press pulse and serial code-bit encoder.
// Optional auto-repeat while a key is held is enabled by defining HOLD_REPEAT_EN.
module key_debounce_encoder #(
  parameter int DB_CYCLES     = 20,
  parameter int REPEAT_CYCLES = 5000
) (
  input  logic clk,
  input  logic rst,
  input  logic key0,
  input  logic key1,
  output logic key0_pulse,
  output logic key1_pulse,
  output logic bit_valid,
  output logic bit_value,
  output logic collide,
  output logic busy
);

  // state        | meaning
  // IDLE         | key released and debounced
  // PRESS_WAIT   | key seen high, counting stable high samples
  // PRESSED      | press accepted, pulse issued on entry
  // RELEASE_WAIT | key seen low, counting stable low samples
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

  localparam logic [15:0] DB_LAST = 16'(DB_CYCLES - 1);

  logic [1:0]  sync1_q, sync2_q;
  state_t      state_q [2];
  state_t      state_d [2];
  logic [15:0] cnt_q [2];
  logic [15:0] cnt_d [2];
  logic [1:0]  pulse_q, pulse_d;
  logic [1:0]  locked;
  logic        valid_d, collide_d, value_d;
  logic        bit_valid_q, bit_value_q, collide_q;

`ifdef HOLD_REPEAT_EN
  localparam logic [15:0] REP_LAST = 16'(REPEAT_CYCLES - 1);
  logic [15:0] rep_q [2];
  logic [15:0] rep_d [2];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      pulse_q <= '0;
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
`ifdef HOLD_REPEAT_EN
        rep_q[i]   <= '0;
`endif
      end
    end else begin
      sync1_q <= {key1, key0};
      sync2_q <= sync1_q;
      pulse_q <= pulse_d;
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
`ifdef HOLD_REPEAT_EN
        rep_q[i]   <= rep_d[i];
`endif
      end
    end
  end

  always_comb begin
    pulse_d = '0;
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
`ifdef HOLD_REPEAT_EN
      // Default of zero clears the repeat count everywhere except while held in PRESSED.
      rep_d[i]   = '0;
`endif
      case (state_q[i])
        IDLE: begin
          if (sync2_q[i]) begin
            state_d[i] = PRESS_WAIT;
            cnt_d[i]   = 16'd1;
          end
        end
        PRESS_WAIT: begin
          if (!sync2_q[i]) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == DB_LAST) begin
            state_d[i] = PRESSED;
            cnt_d[i]   = '0;
            pulse_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + 16'd1;
          end
        end
        PRESSED: begin
          if (!sync2_q[i]) begin
            state_d[i] = RELEASE_WAIT;
            cnt_d[i]   = 16'd1;
          end else begin
`ifdef HOLD_REPEAT_EN
            if (rep_q[i] == REP_LAST) begin
              pulse_d[i] = 1'b1;
            end else begin
              rep_d[i] = rep_q[i] + 16'd1;
            end
`endif
          end
        end
        RELEASE_WAIT: begin
          if (sync2_q[i]) begin
            state_d[i] = PRESSED;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == DB_LAST) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + 16'd1;
          end
        end
        default: begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // A channel holding an accepted press locks out code bits from the other one.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      locked[i] = (state_q[i] == PRESSED) || (state_q[i] == RELEASE_WAIT);
    end
    collide_d = pulse_q[0] & pulse_q[1];
    valid_d   = ((pulse_q == 2'b01) && !locked[1]) || ((pulse_q == 2'b10) && !locked[0]);
    value_d   = valid_d ? pulse_q[1] : bit_value_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_valid_q <= 1'b0;
      bit_value_q <= 1'b0;
      collide_q   <= 1'b0;
    end else begin
      bit_valid_q <= valid_d;
      bit_value_q <= value_d;
      collide_q   <= collide_d;
    end
  end

  assign key0_pulse = pulse_q[0];
  assign key1_pulse = pulse_q[1];
  assign bit_valid  = bit_valid_q;
  assign bit_value  = bit_value_q;
  assign collide    = collide_q;
  assign busy       = (state_q[0] != IDLE) || (state_q[1] != IDLE);

endmodule

// File: tb/tb_key_debounce_encoder.sv
// Bench for key_debounce_encoder: directed scenarios plus random key traffic against a
// run-length reference model. Define HOLD_REPEAT_EN to also exercise auto-repeat.
module tb_key_debounce_encoder;
  localparam int DB  = 20;
  localparam int REP = 50;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key0 = 1'b0;
  logic key1 = 1'b0;
  logic key0_pulse, key1_pulse, bit_valid, bit_value, collide, busy;

  always #5 clk = ~clk;

  key_debounce_encoder #(.DB_CYCLES(DB), .REPEAT_CYCLES(REP)) dut (
    .clk(clk), .rst(rst), .key0(key0), .key1(key1),
    .key0_pulse(key0_pulse), .key1_pulse(key1_pulse),
    .bit_valid(bit_valid), .bit_value(bit_value),
    .collide(collide), .busy(busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: synchronised sample history, run length of equal samples, debounced level.
  logic m_s1 [2], m_s2 [2], m_last [2], m_lvl [2], m_p [2];
  int   m_run [2], m_rep [2];
  logic e_valid, e_value, e_col;

  task automatic model_edge(input logic r, input logic k0, input logic k1);
    logic k [2];
    logic samp, newp;
    k[0] = k0;
    k[1] = k1;
    if (r) begin
      for (int i = 0; i < 2; i++) begin
        m_s1[i] = 0; m_s2[i] = 0; m_last[i] = 0; m_lvl[i] = 0; m_p[i] = 0;
        m_run[i] = 0; m_rep[i] = 0;
      end
      e_valid = 0; e_value = 0; e_col = 0;
    end else begin
      e_col   = m_p[0] & m_p[1];
      e_valid = (m_p[0] != m_p[1]) && !(m_p[0] ? m_lvl[1] : m_lvl[0]);
      if (e_valid) e_value = m_p[1];
      for (int i = 0; i < 2; i++) begin
        samp    = m_s2[i];
        m_s2[i] = m_s1[i];
        m_s1[i] = k[i];
        m_run[i] = (samp == m_last[i]) ? m_run[i] + 1 : 1;
        m_last[i] = samp;
        newp = 0;
        if (m_lvl[i] != samp && m_run[i] >= DB) begin
          m_lvl[i] = samp;
          newp = samp;
          m_rep[i] = 0;
        end else begin
`ifdef HOLD_REPEAT_EN
          if (m_lvl[i] && samp && m_run[i] >= 2) begin
            m_rep[i]++;
            if (m_rep[i] == REP) begin
              m_rep[i] = 0;
              newp = 1;
            end
          end else begin
            m_rep[i] = 0;
          end
`endif
        end
        m_p[i] = newp;
      end
    end
  endtask

  int edge_n, first_p1, first_bv, n_p0, n_p1, n_both, n_bv, n_col;

  task automatic clr_stats();
    edge_n = 0; first_p1 = 0; first_bv = 0;
    n_p0 = 0; n_p1 = 0; n_both = 0; n_bv = 0; n_col = 0;
  endtask

  task automatic step(input logic r, input logic k0, input logic k1);
    logic [5:0] exp_v;
    @(negedge clk);
    rst  = r;
    key0 = k0;
    key1 = k1;
    @(posedge clk);
    model_edge(r, k0, k1);
    #1;
    exp_v = {m_p[0], m_p[1], e_valid, e_value, e_col,
             m_lvl[0] | m_last[0] | m_lvl[1] | m_last[1]};
    check("outputs k0p,k1p,bv,bval,col,busy",
          {26'd0, key0_pulse, key1_pulse, bit_valid, bit_value, collide, busy},
          {26'd0, exp_v});
    edge_n++;
    if (key1_pulse && first_p1 == 0) first_p1 = edge_n;
    if (bit_valid && first_bv == 0) first_bv = edge_n;
    n_p0   += int'(key0_pulse);
    n_p1   += int'(key1_pulse);
    n_both += int'(key0_pulse & key1_pulse);
    n_bv   += int'(bit_valid);
    n_col  += int'(collide);
  endtask

  task automatic run(input int n, input logic k0, input logic k1);
    for (int i = 0; i < n; i++) step(1'b0, k0, k1);
  endtask

  initial begin
    int seg, len;
    logic r0, r1;

    // single key1 press: pulse at edge 22, code bit at edge 23
    step(1, 0, 0);
    step(1, 0, 0);
    clr_stats();
    run(60, 0, 1);
    run(40, 0, 0);
    check("t1 key1 pulse edge", first_p1, 22);
    check("t1 bit_valid edge", first_bv, 23);
    check("t1 key1 pulse count", n_p1, 1);
    check("t1 bit_valid count", n_bv, 1);
    check("t1 bit_value", bit_value, 1);
    check("t1 busy after release", busy, 0);

    // short glitch is rejected
    clr_stats();
    run(10, 1, 0);
    run(40, 0, 0);
    check("t2 glitch pulses", n_p0, 0);
    check("t2 glitch bit_valid", n_bv, 0);
    check("t2 busy", busy, 0);

    // release bounce inside a long press
    clr_stats();
    run(30, 1, 0);
    run(5, 0, 0);
    run(25, 1, 0);
    run(40, 0, 0);
    check("t3 bounce key0 pulses", n_p0, 1);
    check("t3 bounce bit_valid", n_bv, 1);
    check("t3 bit_value", bit_value, 0);

    // simultaneous press collides
    clr_stats();
    run(60, 1, 1);
    run(40, 0, 0);
    check("t4 both pulses same cycle", n_both, 1);
    check("t4 collide count", n_col, 1);
    check("t4 bit_valid count", n_bv, 0);

    // key1 pressed while key0 held is locked out
    clr_stats();
    run(50, 1, 0);
    run(60, 1, 1);
    run(90, 1, 0);
    run(40, 0, 0);
    check("t5 key1 pulses", n_p1, 1);
    check("t5 bit_valid count", n_bv, 1);
    check("t5 bit_value", bit_value, 0);

`ifdef HOLD_REPEAT_EN
    clr_stats();
    run(200, 0, 1);
    run(40, 0, 0);
    check("t6 repeat pulses", n_p1, 4);
    check("t6 repeat bit_valid", n_bv, 4);
    check("t6 bit_value", bit_value, 1);
`endif

    // reset mid-hold: key still down afterwards is a fresh press
    run(30, 0, 1);
    step(1, 0, 1);
    check("reset clears outputs", {key0_pulse, key1_pulse, bit_valid, bit_value, collide, busy}, 0);
    step(1, 0, 1);
    clr_stats();
    run(40, 0, 1);
    check("t7 post-reset pulse edge", first_p1, 22);
    check("t7 post-reset pulse count", n_p1, 1);
    run(40, 0, 0);

    // random traffic against the model
    for (seg = 0; seg < 120; seg++) begin
      if ($urandom_range(0, 29) == 0) begin
        len = $urandom_range(1, 3);
        for (int i = 0; i < len; i++) step(1, $urandom_range(0, 1), $urandom_range(0, 1));
      end else begin
        r0 = 1'($urandom_range(0, 1));
        r1 = 1'($urandom_range(0, 1));
        len = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 8) : $urandom_range(15, 70);
        run(len, r0, r1);
      end
    end
    run(50, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
